// File: rtl/cpu_mem_bridge.sv
// Bridges phi0-timed CPU accesses onto the PSRAM memory controller request port.
// Keeps a one-entry read cache so a repeated read of the same address is served without a memory access.
module cpu_mem_bridge #(
   parameter logic [5:0]  BANK    = 6'd0,
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_phi0,
   input  logic [15:0] i_addr,
   input  logic        i_we,
   input  logic [7:0]  i_cpuData,
   input  logic        i_busy,
   input  logic        i_dataReady,
   input  logic [7:0]  i_memData,
   output logic        o_cs,
   output logic        o_write,
   output logic [5:0]  o_bank,
   output logic [15:0] o_addr,
   output logic [7:0]  o_dataToWrite,
   output logic [7:0]  o_cpuData,
   output logic        o_rdy,
   output logic        o_timeout,
   output logic        o_overrun
);

   typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;

   localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

   state_t      state;
   logic        sync1, sync2, sync3;
   logic        prime1, prime2, seen_low;
   logic        phi_rise;
   logic        cache_vld;
   logic [15:0] cache_addr;
   logic [7:0]  cache_data;
   logic [15:0] cnt;

   assign o_bank = BANK;

   // prime1/prime2 mark when sync2 holds a real sample, so a phi0 that is already
   // high when reset is released must first be seen low before it can make an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync3    <= 1'b0;
         prime1   <= 1'b0;
         prime2   <= 1'b0;
         seen_low <= 1'b0;
      end else begin
         sync1  <= i_phi0;
         sync2  <= sync1;
         sync3  <= sync2;
         prime1 <= 1'b1;
         prime2 <= prime1;
         if (prime2 && !sync2)
            seen_low <= 1'b1;
      end
   end

   assign phi_rise = sync2 & ~sync3 & seen_low;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         o_cs          <= 1'b0;
         o_write       <= 1'b0;
         o_addr        <= 16'h0000;
         o_dataToWrite <= 8'h00;
         o_cpuData     <= 8'h00;
         o_rdy         <= 1'b1;
         o_timeout     <= 1'b0;
         o_overrun     <= 1'b0;
         cache_vld     <= 1'b0;
         cache_addr    <= 16'h0000;
         cache_data    <= 8'h00;
         cnt           <= 16'h0000;
      end else begin
         o_cs <= 1'b0;
         if (phi_rise && state != IDLE)
            o_overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (phi_rise) begin
                  if (!i_we && cache_vld && i_addr == cache_addr) begin
                     o_cpuData <= cache_data;
                  end else begin
                     state         <= ARM;
                     o_rdy         <= 1'b0;
                     o_addr        <= i_addr;
                     o_write       <= i_we;
                     o_dataToWrite <= i_cpuData;
                  end
               end
            end
            ARM: begin
               if (!i_busy) begin
                  o_cs  <= 1'b1;
                  cnt   <= 16'h0000;
                  state <= WAIT;
               end
            end
            WAIT: begin
               // Completion takes priority over a timeout landing in the same cycle.
               if (i_dataReady) begin
                  cache_vld  <= 1'b1;
                  cache_addr <= o_addr;
                  if (o_write) begin
                     cache_data <= o_dataToWrite;
                  end else begin
                     cache_data <= i_memData;
                     o_cpuData  <= i_memData;
                  end
                  state <= DONE;
               end else if (cnt == TO_LAST) begin
                  o_timeout <= 1'b1;
                  o_cpuData <= 8'hFF;
                  cache_vld <= 1'b0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DONE: begin
               o_rdy <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: misses, hits, write-through, busy stall,
// timeout, overrun and reset in the middle of an access.
module tb_cpu_mem_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_phi0 = 1'b0;
   logic [15:0] i_addr = 16'h0000;
   logic        i_we = 1'b0;
   logic [7:0]  i_cpuData = 8'h00;
   logic        i_busy = 1'b0;
   logic        i_dataReady = 1'b0;
   logic [7:0]  i_memData = 8'h00;
   logic        o_cs, o_write, o_rdy, o_timeout, o_overrun;
   logic [5:0]  o_bank;
   logic [15:0] o_addr;
   logic [7:0]  o_dataToWrite, o_cpuData;

   int n_vec = 0;
   int n_err = 0;
   int cs_cnt = 0;
   int cs0;

   cpu_mem_bridge #(.BANK(6'd5), .TIMEOUT(16'd16)) dut (
      .clk(clk), .reset(reset), .i_phi0(i_phi0), .i_addr(i_addr), .i_we(i_we),
      .i_cpuData(i_cpuData), .i_busy(i_busy), .i_dataReady(i_dataReady),
      .i_memData(i_memData), .o_cs(o_cs), .o_write(o_write), .o_bank(o_bank),
      .o_addr(o_addr), .o_dataToWrite(o_dataToWrite), .o_cpuData(o_cpuData),
      .o_rdy(o_rdy), .o_timeout(o_timeout), .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (o_cs) cs_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_edge(input logic [15:0] a, input logic w, input logic [7:0] d);
      i_addr = a; i_we = w; i_cpuData = d;
      i_phi0 = 1'b1;
      tick(3);
      i_phi0 = 1'b0;
   endtask

   task automatic wait_cs();
      int n = 0;
      while (!o_cs && n < 40) begin
         tick(1);
         n++;
      end
      chk("cs_seen", {31'd0, o_cs}, 32'd1);
   endtask

   task automatic ready_pulse(input logic [7:0] d);
      i_memData = d;
      i_dataReady = 1'b1;
      tick(1);
      i_dataReady = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cs"}, {31'd0, o_cs}, 32'd0);
      chk({tag, "_write"}, {31'd0, o_write}, 32'd0);
      chk({tag, "_addr"}, {16'd0, o_addr}, 32'h0000);
      chk({tag, "_wdata"}, {24'd0, o_dataToWrite}, 32'h00);
      chk({tag, "_rdata"}, {24'd0, o_cpuData}, 32'h00);
      chk({tag, "_rdy"}, {31'd0, o_rdy}, 32'd1);
      chk({tag, "_bank"}, {26'd0, o_bank}, 32'd5);
      chk({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
      chk({tag, "_overrun"}, {31'd0, o_overrun}, 32'd0);
   endtask

   initial begin
      tick(2);
      chk_reset_vals("rst");
      reset = 1'b1;
      tick(5);

      // read miss at C000
      cs0 = cs_cnt;
      cpu_edge(16'hC000, 1'b0, 8'h00);
      chk("miss_rdy_low", {31'd0, o_rdy}, 32'd0);
      chk("miss_addr", {16'd0, o_addr}, 32'hC000);
      chk("miss_write", {31'd0, o_write}, 32'd0);
      wait_cs();
      tick(4);
      ready_pulse(8'h8D);
      chk("miss_rdy_done", {31'd0, o_rdy}, 32'd0);
      chk("miss_data", {24'd0, o_cpuData}, 32'h8D);
      tick(1);
      chk("miss_rdy_back", {31'd0, o_rdy}, 32'd1);
      tick(3);
      chk("miss_cs_count", cs_cnt - cs0, 32'd1);

      // read hit at C000
      cs0 = cs_cnt;
      cpu_edge(16'hC000, 1'b0, 8'h00);
      chk("hit_rdy", {31'd0, o_rdy}, 32'd1);
      tick(8);
      chk("hit_data", {24'd0, o_cpuData}, 32'h8D);
      chk("hit_cs_count", cs_cnt - cs0, 32'd0);

      // write 79 to D020, then read it back from the cache
      cs0 = cs_cnt;
      cpu_edge(16'hD020, 1'b1, 8'h79);
      chk("wr_write", {31'd0, o_write}, 32'd1);
      chk("wr_wdata", {24'd0, o_dataToWrite}, 32'h79);
      chk("wr_addr", {16'd0, o_addr}, 32'hD020);
      wait_cs();
      tick(2);
      ready_pulse(8'h00);
      tick(1);
      chk("wr_rdy_back", {31'd0, o_rdy}, 32'd1);
      tick(4);
      cpu_edge(16'hD020, 1'b0, 8'h00);
      tick(6);
      chk("wr_hit_data", {24'd0, o_cpuData}, 32'h79);
      chk("wr_cs_count", cs_cnt - cs0, 32'd1);

      // busy stall then timeout at the wrap address FFFF
      cs0 = cs_cnt;
      i_busy = 1'b1;
      cpu_edge(16'hFFFF, 1'b0, 8'h00);
      chk("to_addr", {16'd0, o_addr}, 32'hFFFF);
      tick(10);
      chk("to_busy_no_cs", cs_cnt - cs0, 32'd0);
      chk("to_busy_rdy", {31'd0, o_rdy}, 32'd0);
      i_busy = 1'b0;
      wait_cs();
      tick(15);
      chk("to_not_yet", {31'd0, o_timeout}, 32'd0);
      tick(1);
      chk("to_flag", {31'd0, o_timeout}, 32'd1);
      chk("to_data", {24'd0, o_cpuData}, 32'hFF);
      tick(1);
      chk("to_rdy_back", {31'd0, o_rdy}, 32'd1);
      chk("to_no_overrun", {31'd0, o_overrun}, 32'd0);
      tick(3);
      chk("to_cs_count", cs_cnt - cs0, 32'd1);

      // second edge during WAIT
      cs0 = cs_cnt;
      cpu_edge(16'h2000, 1'b0, 8'h00);
      wait_cs();
      tick(2);
      cpu_edge(16'h3000, 1'b0, 8'h00);
      chk("ov_flag", {31'd0, o_overrun}, 32'd1);
      chk("ov_addr_kept", {16'd0, o_addr}, 32'h2000);
      ready_pulse(8'h5A);
      tick(1);
      chk("ov_rdy_back", {31'd0, o_rdy}, 32'd1);
      chk("ov_data", {24'd0, o_cpuData}, 32'h5A);
      tick(8);
      chk("ov_cs_count", cs_cnt - cs0, 32'd1);
      chk("ov_sticky", {31'd0, o_overrun}, 32'd1);

      // reset in WAIT, with phi0 held high across the release
      cpu_edge(16'h4000, 1'b0, 8'h00);
      wait_cs();
      tick(2);
      cs0 = cs_cnt;
      #2 reset = 1'b0;
      #1 chk_reset_vals("midrst");
      i_phi0 = 1'b1;
      tick(2);
      #2 reset = 1'b1;
      tick(10);
      chk("rel_no_cs", cs_cnt - cs0, 32'd0);
      chk("rel_rdy", {31'd0, o_rdy}, 32'd1);
      i_phi0 = 1'b0;
      tick(4);
      cpu_edge(16'h2000, 1'b0, 8'h00);
      chk("post_rst_miss", {31'd0, o_rdy}, 32'd0);
      chk("post_rst_addr", {16'd0, o_addr}, 32'h2000);
      wait_cs();
      tick(2);
      ready_pulse(8'h33);
      tick(1);
      chk("post_rst_data", {24'd0, o_cpuData}, 32'h33);
      chk("post_rst_rdy", {31'd0, o_rdy}, 32'd1);
      tick(3);
      chk("post_rst_cs", cs_cnt - cs0, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
